instruction_fetch_sequencer: RTL and testbench
==============================================

# instruction_fetch_sequencer

Sequences instruction-memory reads for the fetch stage. It sits directly upstream of the instruction fetch controller:
- samples the current `programCounter`;
- issues one read request to instruction memory and waits for the response;
- presents the fetched word on the controller's `memoryIn`, pulsing `cir_writeEnable` and `pc_writeEnable` together for exactly one cycle per delivered instruction.

It also handles downstream stall, redirect flush and a memory-response timeout.

## Interface
- `TIMEOUT_CYCLES`, 255, maximum cycles waiting for a response before abort; 0 disables the timeout
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `programCounter`  in  `DATA_WIDTH`  current PC from the fetch controller
- `fetchEnable`  in  1  core running; gates only the start of a new fetch
- `stall`  in  1  downstream cannot accept an instruction this cycle
- `flush`  in  1  redirect; discard any fetch in progress
- `memReadReq`  out  1  read request valid
- `memReadAddr`  out  `DATA_WIDTH`  read address, stable while `memReadReq`=1
- `memReadAck`  in  1  memory accepted the request this cycle
- `memReadValid`  in  1  response data valid
- `memReadData`  in  `INSTRUCTION_WIDTH`  response data
- `instrData`  out  `INSTRUCTION_WIDTH`  fetched instruction; drives controller `memoryIn`
- `cir_writeEnable`  out  1  load instruction register
- `pc_writeEnable`  out  1  advance or redirect PC
- `busy`  out  1  state ≠ IDLE
- `fetchTimeout`  out  1  sticky; a response timed out

## Operation
The FSM has five states: IDLE, REQUEST, WAIT, DELIVER and DRAIN. `flush` has priority over `memReadValid`, `stall` and the timeout.
- **IDLE:** if `fetchEnable` and not `stall`, latch `programCounter` into `memReadAddr` and go to REQUEST. `flush` has no effect here.
- **REQUEST:** `memReadReq`=1.
  - `memReadAck`=1 and `memReadValid`=1: capture `memReadData` into `instrData`, go to DELIVER.
  - `memReadAck`=1 only: go to WAIT.
  - `flush` with `memReadAck`=1: go to DRAIN, or to IDLE if `memReadValid` is also 1.
  - `flush` without `memReadAck`: go to IDLE. The request is withdrawn.
- **WAIT:**
  - `memReadValid`: capture data, go to DELIVER.
  - `flush`: go to DRAIN, or to IDLE if `memReadValid` is also 1 (data discarded).
  - Timeout counter reaches `TIMEOUT_CYCLES`: set `fetchTimeout`, go to IDLE.
- **DELIVER:**
  - Not `stall` and not `flush`: `cir_writeEnable`=`pc_writeEnable`=1 this cycle, go to IDLE.
  - `stall`: hold `instrData`; enables stay 0.
  - `flush`: go to IDLE with no enables.
- **DRAIN:** wait for `memReadValid`, discard the data, go to IDLE. The timeout also applies here and sets `fetchTimeout`.
- Timeout counter:
  - Cleared on entry to WAIT or DRAIN; increments each cycle in those states.
  - Width is `$clog2(TIMEOUT_CYCLES+1)`, and the counter saturates.
- `fetchEnable` deasserting mid-fetch does not abort; the current fetch completes.
- `fetchTimeout` clears only on reset.
- A late `memReadValid` arriving in IDLE, after a timeout or a withdrawn request, is ignored.

## Timing
- Reset values: state IDLE, `memReadReq` 0, `memReadAddr` 0, `instrData` 0, `cir_writeEnable` 0, `pc_writeEnable` 0, `busy` 0, `fetchTimeout` 0, counter 0. Reset may assert in any state and returns to IDLE immediately.
- `memReadAddr`, `instrData`, state, counter and `fetchTimeout` are registered.
- `memReadReq` and `busy` decode from state.
- The write enables are combinational from state, `stall` and `flush`.
- Zero-wait memory: IDLE(t) → REQUEST(t+1) → DELIVER(t+2, enables high) → IDLE(t+3). That is 3 cycles per instruction.
- An N-cycle response delay adds N cycles in WAIT.
- `programCounter` is sampled only on the IDLE→REQUEST edge. The PC update caused by a DELIVER pulse is visible when IDLE is reached.

## Structure
- Shared `globalVariables.v` holds:
  - `FETCH_STATE_*` encodings (3-bit);
  - `DATA_WIDTH` and `INSTRUCTION_WIDTH`, reused as-is.
- Sub-module `fetch_timeout_counter` (clear, enable, `TIMEOUT_CYCLES` compare, saturate) is natural. Everything else stays in a single FSM module.

## Test plan
- **Zero-wait fetch:** PC=0x00, memory acks and returns 0x00500093 in the same cycle → `instrData`=0x00500093, enables high for exactly 1 cycle at t+2; next request address 0x04.
- **Wait states:** `memReadValid` 3 cycles after ack → DELIVER at t+5, single enable pulse, `memReadAddr` stable while `memReadReq`=1.
- **Stall in DELIVER:** `stall` held 4 cycles → enables stay 0, `instrData` held; pulse on the first unstalled cycle.
- **Flush in WAIT:** flush with response pending → DRAIN, response 0xDEADBEEF discarded (`instrData` unchanged, no enables); next fetch uses the redirected PC 0x100.
- **Timeout:** `TIMEOUT_CYCLES`=8, ack but no valid → `fetchTimeout`=1 after 8 WAIT cycles, back to IDLE; a late `memReadValid` is ignored; sticky until reset.
- **Async reset mid-WAIT:** `reset`=0 between clock edges → all outputs at reset values immediately; a normal fetch follows reset release.

Source files
------------

// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared widths and fetch FSM encodings for the instruction fetch sequencer.
// Widths match the fetch controller's datapath and are reused unchanged.
package instruction_fetch_sequencer_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int INSTRUCTION_WIDTH = 32;

  typedef enum logic [2:0] {
    FETCH_STATE_IDLE    = 3'd0,
    FETCH_STATE_REQUEST = 3'd1,
    FETCH_STATE_WAIT    = 3'd2,
    FETCH_STATE_DELIVER = 3'd3,
    FETCH_STATE_DRAIN   = 3'd4
  } fetch_state_t;

  // States in which an accepted request still owes us a response.
  function automatic logic awaiting_response(input fetch_state_t s);
    return (s == FETCH_STATE_WAIT) || (s == FETCH_STATE_DRAIN);
  endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_timeout_counter.sv
// Saturating response-timeout counter; TIMEOUT_CYCLES of 0 disables expiry.
// expired fires on the cycle whose increment brings the count to TIMEOUT_CYCLES.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         count <= '0;
    else if (clear)                     count <= '0;
    else if (enable && count != LIMIT)  count <= count + CW'(1);
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT - CW'(1));

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch-stage memory read sequencer: one request per instruction, single-cycle
// CIR/PC write pulse on delivery, with stall, redirect flush and response timeout.
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        programCounter,
  input  logic                         fetchEnable,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         memReadReq,
  output logic [DATA_WIDTH-1:0]        memReadAddr,
  input  logic                         memReadAck,
  input  logic                         memReadValid,
  input  logic [INSTRUCTION_WIDTH-1:0] memReadData,
  output logic [INSTRUCTION_WIDTH-1:0] instrData,
  output logic                         cir_writeEnable,
  output logic                         pc_writeEnable,
  output logic                         busy,
  output logic                         fetchTimeout
);

  fetch_state_t state, next_state;
  logic start, capture, set_timeout;
  logic cnt_clear, cnt_enable, expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH_STATE_IDLE;
    else        state <= next_state;
  end

  // flush outranks response, stall and timeout in every busy state but DRAIN,
  // where the outstanding response must still be absorbed.
  always_comb begin
    next_state  = state;
    start       = 1'b0;
    capture     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      FETCH_STATE_IDLE:
        if (fetchEnable && !stall) begin
          start      = 1'b1;
          next_state = FETCH_STATE_REQUEST;
        end
      FETCH_STATE_REQUEST:
        if (flush) begin
          if (memReadAck && !memReadValid) next_state = FETCH_STATE_DRAIN;
          else                             next_state = FETCH_STATE_IDLE;
        end else if (memReadAck && memReadValid) begin
          capture    = 1'b1;
          next_state = FETCH_STATE_DELIVER;
        end else if (memReadAck) begin
          next_state = FETCH_STATE_WAIT;
        end
      FETCH_STATE_WAIT:
        if (flush) begin
          next_state = memReadValid ? FETCH_STATE_IDLE : FETCH_STATE_DRAIN;
        end else if (memReadValid) begin
          capture    = 1'b1;
          next_state = FETCH_STATE_DELIVER;
        end else if (expired) begin
          set_timeout = 1'b1;
          next_state  = FETCH_STATE_IDLE;
        end
      FETCH_STATE_DELIVER:
        if (flush || !stall) next_state = FETCH_STATE_IDLE;
      FETCH_STATE_DRAIN:
        if (memReadValid) begin
          next_state = FETCH_STATE_IDLE;
        end else if (expired) begin
          set_timeout = 1'b1;
          next_state  = FETCH_STATE_IDLE;
        end
      default: next_state = FETCH_STATE_IDLE;
    endcase
  end

  always_comb begin
    memReadReq      = 1'b0;
    busy            = 1'b0;
    cir_writeEnable = 1'b0;
    pc_writeEnable  = 1'b0;
    memReadReq      = (state == FETCH_STATE_REQUEST);
    busy            = (state != FETCH_STATE_IDLE);
    if (state == FETCH_STATE_DELIVER && !stall && !flush) begin
      cir_writeEnable = 1'b1;
      pc_writeEnable  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memReadAddr  <= '0;
      instrData    <= '0;
      fetchTimeout <= 1'b0;
    end else begin
      if (start)       memReadAddr  <= programCounter;
      if (capture)     instrData    <= memReadData;
      if (set_timeout) fetchTimeout <= 1'b1;
    end
  end

  // Counter restarts only on entry, so WAIT->DRAIN gets a fresh budget.
  assign cnt_clear  = awaiting_response(next_state) && (next_state != state);
  assign cnt_enable = awaiting_response(state);

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(expired)
  );

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer with an 8-cycle timeout.
// Inputs change 1ns after each rising edge; checks are taken at that point.
module tb_instruction_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] programCounter;
  logic        fetchEnable, stall, flush;
  logic        memReadReq;
  logic [31:0] memReadAddr;
  logic        memReadAck, memReadValid;
  logic [31:0] memReadData;
  logic [31:0] instrData;
  logic        cir_writeEnable, pc_writeEnable, busy, fetchTimeout;

  int n_assert = 0;
  int n_fail   = 0;

  instruction_fetch_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .programCounter (programCounter),
    .fetchEnable    (fetchEnable),
    .stall          (stall),
    .flush          (flush),
    .memReadReq     (memReadReq),
    .memReadAddr    (memReadAddr),
    .memReadAck     (memReadAck),
    .memReadValid   (memReadValid),
    .memReadData    (memReadData),
    .instrData      (instrData),
    .cir_writeEnable(cir_writeEnable),
    .pc_writeEnable (pc_writeEnable),
    .busy           (busy),
    .fetchTimeout   (fetchTimeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; programCounter = '0; fetchEnable = 1'b0; stall = 1'b0; flush = 1'b0;
    memReadAck = 1'b0; memReadValid = 1'b0; memReadData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",  {31'b0, memReadReq}, 32'd0);
    chk("rst_addr", memReadAddr, 32'd0);
    chk("rst_instr", instrData, 32'd0);
    chk("rst_we",   {30'b0, cir_writeEnable, pc_writeEnable}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_tmo",  {31'b0, fetchTimeout}, 32'd0);
    reset = 1'b1;

    // Zero-wait fetch at PC 0
    programCounter = 32'h0; fetchEnable = 1'b1;
    step();
    chk("zw_req",  {31'b0, memReadReq}, 32'd1);
    chk("zw_addr", memReadAddr, 32'h0);
    fetchEnable = 1'b0; memReadAck = 1'b1; memReadValid = 1'b1; memReadData = 32'h00500093;
    step();
    memReadAck = 1'b0; memReadValid = 1'b0; #1;
    chk("zw_instr", instrData, 32'h00500093);
    chk("zw_we",    {30'b0, cir_writeEnable, pc_writeEnable}, 32'd3);
    step();
    chk("zw_we_off", {30'b0, cir_writeEnable, pc_writeEnable}, 32'd0);
    chk("zw_idle",  {31'b0, busy}, 32'd0);

    // Three wait cycles after ack at PC 4
    programCounter = 32'h4; fetchEnable = 1'b1;
    step();
    chk("ws_addr", memReadAddr, 32'h4);
    fetchEnable = 1'b0; programCounter = 32'h88; memReadAck = 1'b1;
    step();
    memReadAck = 1'b0; #1;
    chk("ws_req_off", {31'b0, memReadReq}, 32'd0);
    chk("ws_addr_hold", memReadAddr, 32'h4);
    step();
    step();
    chk("ws_no_we", {30'b0, cir_writeEnable, pc_writeEnable}, 32'd0);
    memReadValid = 1'b1; memReadData = 32'h00A00113;
    step();
    memReadValid = 1'b0; #1;
    chk("ws_instr", instrData, 32'h00A00113);
    chk("ws_we",    {30'b0, cir_writeEnable, pc_writeEnable}, 32'd3);
    step();

    // Stall held for four DELIVER cycles
    programCounter = 32'h8; fetchEnable = 1'b1;
    step();
    fetchEnable = 1'b0; memReadAck = 1'b1; memReadValid = 1'b1; memReadData = 32'h12345678; stall = 1'b1;
    step();
    memReadAck = 1'b0; memReadValid = 1'b0; memReadData = 32'hFFFFFFFF; #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_we_low", {30'b0, cir_writeEnable, pc_writeEnable}, 32'd0);
      step();
    end
    chk("st_we_low4", {30'b0, cir_writeEnable, pc_writeEnable}, 32'd0);
    chk("st_instr",  instrData, 32'h12345678);
    stall = 1'b0; #1;
    chk("st_we", {30'b0, cir_writeEnable, pc_writeEnable}, 32'd3);
    step();
    chk("st_idle", {31'b0, busy}, 32'd0);

    // Flush while a response is pending, then redirected fetch
    programCounter = 32'hC; fetchEnable = 1'b1;
    step();
    fetchEnable = 1'b0; memReadAck = 1'b1;
    step();
    memReadAck = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; programCounter = 32'h100; #1;
    chk("fl_drain_busy", {31'b0, busy}, 32'd1);
    chk("fl_drain_req",  {31'b0, memReadReq}, 32'd0);
    step();
    memReadValid = 1'b1; memReadData = 32'hDEADBEEF; #1;
    chk("fl_drain_we", {30'b0, cir_writeEnable, pc_writeEnable}, 32'd0);
    step();
    memReadValid = 1'b0; #1;
    chk("fl_idle",  {31'b0, busy}, 32'd0);
    chk("fl_instr", instrData, 32'h12345678);
    fetchEnable = 1'b1;
    step();
    chk("fl_redir_addr", memReadAddr, 32'h100);
    fetchEnable = 1'b0; memReadAck = 1'b1; memReadValid = 1'b1; memReadData = 32'h00000013;
    step();
    memReadAck = 1'b0; memReadValid = 1'b0; #1;
    chk("fl_redir_instr", instrData, 32'h00000013);
    step();

    // Timeout: ack with no response for 8 WAIT cycles
    programCounter = 32'h104; fetchEnable = 1'b1;
    step();
    fetchEnable = 1'b0; memReadAck = 1'b1;
    step();
    memReadAck = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("to_wait8_busy", {31'b0, busy}, 32'd1);
    chk("to_wait8_flag", {31'b0, fetchTimeout}, 32'd0);
    step();
    chk("to_flag", {31'b0, fetchTimeout}, 32'd1);
    chk("to_idle", {31'b0, busy}, 32'd0);
    memReadValid = 1'b1; memReadData = 32'h00000BAD;
    step();
    memReadValid = 1'b0; #1;
    chk("to_late_busy",  {31'b0, busy}, 32'd0);
    chk("to_late_instr", instrData, 32'h00000013);
    programCounter = 32'h108; fetchEnable = 1'b1;
    step();
    fetchEnable = 1'b0; memReadAck = 1'b1; memReadValid = 1'b1; memReadData = 32'h00108093;
    step();
    memReadAck = 1'b0; memReadValid = 1'b0; #1;
    chk("to_after_instr", instrData, 32'h00108093);
    chk("to_sticky", {31'b0, fetchTimeout}, 32'd1);
    step();

    // Asynchronous reset in WAIT
    programCounter = 32'h200; fetchEnable = 1'b1;
    step();
    fetchEnable = 1'b0; memReadAck = 1'b1;
    step();
    memReadAck = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_busy",  {31'b0, busy}, 32'd0);
    chk("ar_addr",  memReadAddr, 32'd0);
    chk("ar_instr", instrData, 32'd0);
    chk("ar_tmo",   {31'b0, fetchTimeout}, 32'd0);
    chk("ar_req",   {31'b0, memReadReq}, 32'd0);
    step();
    reset = 1'b1;
    programCounter = 32'h300; fetchEnable = 1'b1;
    step();
    chk("ar_post_addr", memReadAddr, 32'h300);
    fetchEnable = 1'b0; memReadAck = 1'b1; memReadValid = 1'b1; memReadData = 32'h00300313;
    step();
    memReadAck = 1'b0; memReadValid = 1'b0; #1;
    chk("ar_post_instr", instrData, 32'h00300313);
    chk("ar_post_we", {30'b0, cir_writeEnable, pc_writeEnable}, 32'd3);
    step();
    chk("ar_post_idle", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
